// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - word handshake, bit strobe and serial output bundle for bit_serializer
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             bit_en;
  logic             out_bit;
  logic             out_valid;
  logic             out_last;
  logic             busy;

  modport master (
    output in_data, in_valid, bit_en,
    input  in_ready, out_bit, out_valid, out_last, busy
  );

  modport slave (
    input  in_data, in_valid, bit_en,
    output in_ready, out_bit, out_valid, out_last, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial converter with one-word holding register
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   LSB_FIRST = 0,
  parameter logic IDLE_BIT  = 1'b1
) (
  input logic            clk,
  input logic            rst,
  bit_serializer_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             active;
  logic             at_last;
  logic             accept;
  logic             load_evt;

  assign active   = (state_q == SHIFT);
  assign at_last  = active & (cnt_q == LAST_IDX);
  assign accept   = bus.in_valid & ~hold_full_q;
  // Idle loads ignore the strobe so a new word starts on the very next cycle.
  assign load_evt = ~active | (bus.bit_en & at_last);

  assign bus.in_ready  = ~hold_full_q;
  assign bus.out_valid = active;
  assign bus.out_bit   = active ? ((LSB_FIRST != 0) ? sh_q[0] : sh_q[WIDTH-1]) : IDLE_BIT;
  assign bus.out_last  = at_last;
  assign bus.busy      = active | hold_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load_evt) begin
      cnt_d = '0;
      if (hold_full_q) begin
        sh_d        = hold_q;
        hold_full_d = 1'b0;
        state_d     = SHIFT;
      end else if (accept) begin
        sh_d    = bus.in_data;
        state_d = SHIFT;
      end else begin
        state_d = IDLE;
      end
    end else if (bus.bit_en) begin
      sh_d  = (LSB_FIRST != 0) ? {1'b0, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
    end
    // A word that cannot go straight into the shifter waits in the holding register.
    if (accept && !load_evt) begin
      hold_d      = bus.in_data;
      hold_full_d = 1'b1;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer (MSB-first and LSB-first instances)
module tb_bit_serializer;
  logic       clk = 1'b0;
  logic       rst;
  logic       iv[2];
  logic       be[2];
  logic [7:0] id[2];
  logic       ob[2], ov[2], ol[2], ir[2], bz[2];

  int n_chk  = 0;
  int n_fail = 0;

  // model: pending words in arrival order, head word is the one on the wire
  logic [7:0] words[2][2];
  int         n[2];
  int         pos[2];
  bit         acc_ev[2];

  logic [31:0] cap_bits[2];
  int          cap_n[2];
  int          cap_last[2];

  bit_serializer_if #(.WIDTH(8)) bm ();
  bit_serializer_if #(.WIDTH(8)) bl ();

  assign bm.in_data  = id[0];
  assign bm.in_valid = iv[0];
  assign bm.bit_en   = be[0];
  assign bl.in_data  = id[1];
  assign bl.in_valid = iv[1];
  assign bl.bit_en   = be[1];
  assign ob[0] = bm.out_bit;  assign ov[0] = bm.out_valid; assign ol[0] = bm.out_last;
  assign ir[0] = bm.in_ready; assign bz[0] = bm.busy;
  assign ob[1] = bl.out_bit;  assign ov[1] = bl.out_valid; assign ol[1] = bl.out_last;
  assign ir[1] = bl.in_ready; assign bz[1] = bl.busy;

  bit_serializer #(.WIDTH(8), .LSB_FIRST(0), .IDLE_BIT(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bm));
  bit_serializer #(.WIDTH(8), .LSB_FIRST(1), .IDLE_BIT(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(bl));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        n[i] = 0; pos[i] = 0; acc_ev[i] = 1'b0;
      end else begin
        acc_ev[i] = (iv[i] === 1'b1) && (n[i] < 2);
        if (n[i] > 0 && be[i] === 1'b1) begin
          if (pos[i] == 7) begin
            words[i][0] = words[i][1];
            n[i]--;
            pos[i] = 0;
          end else begin
            pos[i]++;
          end
        end
        if (acc_ev[i]) begin
          words[i][n[i]] = id[i];
          n[i]++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic eb;
      eb = 1'b1;
      if (n[i] > 0) eb = (i == 0) ? words[i][0][7 - pos[i]] : words[i][0][pos[i]];
      chk($sformatf("out_bit[%0d]", i),   {31'd0, ob[i]}, {31'd0, eb});
      chk($sformatf("out_valid[%0d]", i), {31'd0, ov[i]}, {31'd0, n[i] > 0});
      chk($sformatf("out_last[%0d]", i),  {31'd0, ol[i]}, {31'd0, n[i] > 0 && pos[i] == 7});
      chk($sformatf("busy[%0d]", i),      {31'd0, bz[i]}, {31'd0, n[i] > 0});
      chk($sformatf("in_ready[%0d]", i),  {31'd0, ir[i]}, {31'd0, n[i] < 2});
      if (ov[i] === 1'b1) begin
        cap_bits[i] = {cap_bits[i][30:0], ob[i]};
        cap_n[i]++;
        if (ol[i] === 1'b1) cap_last[i]++;
      end
    end
  end

  task automatic clear_cap();
    for (int i = 0; i < 2; i++) begin
      cap_bits[i] = '0; cap_n[i] = 0; cap_last[i] = 0;
    end
  endtask

  task automatic send(input int i, input logic [7:0] w);
    bit done;
    done  = 1'b0;
    iv[i] = 1'b1;
    id[i] = w;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge clk);
      #1;
      done = acc_ev[i];
    end
    iv[i] = 1'b0;
    chk("send_accepted", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; be[i] = 1'b1; id[i] = 8'h00;
    end
    clear_cap();
    #1;
    chk("rst_out_bit",   {31'd0, ob[0]}, 32'd1);
    chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("rst_in_ready",  {31'd0, ir[0]}, 32'd1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_out_bit",   {31'd0, ob[0]}, 32'd1);
      chk("idle_out_valid", {31'd0, ov[0]}, 32'd0);
      chk("idle_in_ready",  {31'd0, ir[0]}, 32'd1);
      chk("idle_busy",      {31'd0, bz[0]}, 32'd0);
    end

    clear_cap();
    send(0, 8'h49);
    repeat (12) @(posedge clk);
    #1;
    chk("w49_bits", {24'd0, cap_bits[0][7:0]}, 32'h49);
    chk("w49_n",    cap_n[0], 32'd8);
    chk("w49_last", cap_last[0], 32'd1);

    clear_cap();
    send(0, 8'hA5);
    send(0, 8'h3C);
    chk("b2b_ready_drop", {31'd0, ir[0]}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("b2b_bits", {16'd0, cap_bits[0][15:0]}, 32'hA53C);
    chk("b2b_n",    cap_n[0], 32'd16);
    chk("b2b_last", cap_last[0], 32'd2);

    clear_cap();
    be[0] = 1'b0;
    send(0, 8'hF0);
    for (int k = 0; k < 30; k++) begin
      be[0] = (k % 3 == 2);
      @(posedge clk);
      #1;
    end
    be[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("slow_bits", {8'd0, cap_bits[0][23:0]}, 32'hFFF000);
    chk("slow_n",    cap_n[0], 32'd24);
    chk("slow_last", cap_last[0], 32'd3);

    clear_cap();
    send(1, 8'h01);
    repeat (12) @(posedge clk);
    #1;
    chk("lsb_bits", {24'd0, cap_bits[1][7:0]}, 32'h80);
    chk("lsb_n",    cap_n[1], 32'd8);

    clear_cap();
    send(0, 8'hFF);
    send(0, 8'h55);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_busy",     {31'd0, bz[0]}, 32'd1);
    chk("pre_rst_in_ready", {31'd0, ir[0]}, 32'd0);
    chk("pre_rst_bits",     cap_n[0], 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("async_out_valid", {31'd0, ov[0]}, 32'd0);
    chk("async_out_bit",   {31'd0, ob[0]}, 32'd1);
    chk("async_in_ready",  {31'd0, ir[0]}, 32'd1);
    chk("async_busy",      {31'd0, bz[0]}, 32'd0);
    clear_cap();
    #20 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_n", cap_n[0], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
